// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor.
// A direct-mapped BTB with 2-bit saturating counters predicts from the fetch PC.
// Each prediction travels down an I->R->C record pipeline and is graded against
// the C-stage resolution. The BTB is trained from C-stage outcomes.
//
// Ports:
//   clk, reset          - clock (rising edge), synchronous active-high reset
//   PC_I                - PC being fetched (lookup is combinational)
//   Stall / Flush       - hold the record pipeline / kill R and C records
//   Resolve_C ...       - C-stage resolution: PC, direction, jump flag, target
//   Predict, Prediction - taken prediction and target for PC_I (bit 0 is 0)
//   PredictionCorrect_C - C-stage prediction matched the resolved outcome
module branch_predictor #(
    parameter int unsigned BIT_COUNT  = 32,
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] PC_I,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 Resolve_C,
    input  logic [BIT_COUNT-1:0] ResolvePC_C,
    input  logic                 Taken_C,
    input  logic                 IsJump_C,
    input  logic [BIT_COUNT-1:0] ResolvedTarget_C,
    output logic                 Predict,
    output logic [BIT_COUNT-1:0] Prediction,
    output logic                 PredictionCorrect_C
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = BIT_COUNT - INDEX_BITS - 2;

    typedef struct packed {
        logic                 valid;
        logic                 predict;
        logic [BIT_COUNT-1:0] target;
    } rec_t;

    // BTB storage
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [BIT_COUNT-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic                 jump_q   [ENTRIES];

    rec_t r_q, r_d, c_q, c_d;

    // Lookup
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;

    assign lk_idx = PC_I[INDEX_BITS+1:2];
    assign lk_tag = PC_I[BIT_COUNT-1:INDEX_BITS+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        Predict    = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
        Prediction = Predict ? target_q[lk_idx] : '0;
    end

    // Record pipeline: Flush clears validity even while stalled
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (!Stall) begin
            r_d = '{valid: 1'b1, predict: Predict, target: Prediction};
            c_d = r_q;
        end
        if (Flush) begin
            r_d.valid = 1'b0;
            c_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    // Grading of the C-stage record
    logic [BIT_COUNT-1:0] res_target;
    assign res_target = {ResolvedTarget_C[BIT_COUNT-1:1], 1'b0};

    always_comb begin
        PredictionCorrect_C = 1'b0;
        if (Resolve_C && c_q.valid) begin
            PredictionCorrect_C = (Taken_C && c_q.predict && (c_q.target == res_target))
                               || (!Taken_C && !c_q.predict);
        end
    end

    // Training: next contents of the entry addressed by the resolving PC
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic                  up_en;
    logic [BIT_COUNT-1:0]  up_target;
    logic [1:0]            up_ctr;
    logic                  up_jump;

    assign up_idx = ResolvePC_C[INDEX_BITS+1:2];
    assign up_tag = ResolvePC_C[BIT_COUNT-1:INDEX_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_en     = 1'b0;
        up_target = target_q[up_idx];
        up_ctr    = ctr_q[up_idx];
        up_jump   = jump_q[up_idx];
        if (Resolve_C && !Stall) begin
            if (up_hit) begin
                up_en = 1'b1;
                if (IsJump_C) begin
                    up_ctr    = 2'b11;
                    up_jump   = 1'b1;
                    up_target = res_target;
                end else if (Taken_C) begin
                    up_ctr    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    up_jump   = 1'b0;
                    up_target = res_target;
                end else begin
                    up_ctr    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (Taken_C) begin
                // Allocate, evicting whatever aliased into this slot
                up_en     = 1'b1;
                up_ctr    = IsJump_C ? 2'b11 : 2'b10;
                up_jump   = IsJump_C;
                up_target = res_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                jump_q[i]   <= 1'b0;
            end
        end else if (up_en) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= up_target;
            ctr_q[up_idx]    <= up_ctr;
            jump_q[up_idx]   <= up_jump;
        end
    end

    // Byte-offset bits never participate in indexing or comparison
    logic unused_bits;
    assign unused_bits = ^{PC_I[1:0], ResolvePC_C[1:0], ResolvedTarget_C[0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int unsigned BC = 32;
    localparam int unsigned IB = 4;
    localparam int unsigned N  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [BC-1:0] PC_I;
    logic          Stall, Flush, Resolve_C, Taken_C, IsJump_C;
    logic [BC-1:0] ResolvePC_C, ResolvedTarget_C;
    logic          Predict;
    logic [BC-1:0] Prediction;
    logic          PredictionCorrect_C;

    always #5 clk = ~clk;

    branch_predictor #(.BIT_COUNT(BC), .INDEX_BITS(IB)) dut (
        .clk(clk), .reset(reset), .PC_I(PC_I), .Stall(Stall), .Flush(Flush),
        .Resolve_C(Resolve_C), .ResolvePC_C(ResolvePC_C), .Taken_C(Taken_C),
        .IsJump_C(IsJump_C), .ResolvedTarget_C(ResolvedTarget_C),
        .Predict(Predict), .Prediction(Prediction),
        .PredictionCorrect_C(PredictionCorrect_C)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: table of entries keyed by slot number, plus the two
    // in-flight prediction records
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    bit          m_jump   [N];
    bit          mr_v, mr_p, mc_v, mc_p;
    logic [31:0] mr_t, mc_t;

    logic        s_predict, s_correct;
    logic [31:0] s_prediction;

    function automatic int slot_of(logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc >> (IB + 2);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1; m_jump[i] = 0;
        end
        mr_v = 0; mr_p = 0; mr_t = 0; mc_v = 0; mc_p = 0; mc_t = 0;
    endtask

    task automatic model_train(logic [31:0] rpc, bit tk, bit jmp, logic [31:0] tgt);
        int  s;
        bit  hit;
        s   = slot_of(rpc);
        hit = m_valid[s] && (m_tag[s] == tag_of(rpc));
        if (hit) begin
            if (jmp) begin
                m_ctr[s] = 3; m_jump[s] = 1; m_target[s] = tgt;
            end else if (tk) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_target[s] = tgt; m_jump[s] = 0;
            end else begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (tk) begin
            m_valid[s] = 1; m_tag[s] = tag_of(rpc); m_target[s] = tgt;
            m_ctr[s] = jmp ? 3 : 2; m_jump[s] = jmp;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then step past
    // the rising edge so the caller can set up the next cycle's inputs
    task automatic cycle();
        int          s;
        bit          ep, ec;
        logic [31:0] et, rt;
        @(negedge clk);
        s  = slot_of(PC_I);
        ep = m_valid[s] && (m_tag[s] == tag_of(PC_I)) && (m_jump[s] || m_ctr[s] >= 2);
        et = ep ? m_target[s] : 32'h0;
        rt = ResolvedTarget_C & ~32'h1;
        ec = Resolve_C && mc_v && ((Taken_C && mc_p && mc_t == rt) || (!Taken_C && !mc_p));
        s_predict = Predict; s_prediction = Prediction; s_correct = PredictionCorrect_C;
        chk("Predict", 32'(Predict), 32'(ep));
        chk("Prediction", Prediction, et);
        chk("PredictionCorrect_C", 32'(PredictionCorrect_C), 32'(ec));
        if (reset) begin
            model_reset();
        end else begin
            if (Resolve_C && !Stall) model_train(ResolvePC_C, Taken_C, IsJump_C, rt);
            if (!Stall) begin
                mc_v = mr_v; mc_p = mr_p; mc_t = mr_t;
                mr_v = 1; mr_p = ep; mr_t = et;
            end
            if (Flush) begin mr_v = 0; mc_v = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setin(logic [31:0] pc, bit res, logic [31:0] rpc, bit tk, bit jmp,
                         logic [31:0] tgt, bit st, bit fl);
        PC_I = pc; Resolve_C = res; ResolvePC_C = rpc; Taken_C = tk; IsJump_C = jmp;
        ResolvedTarget_C = tgt; Stall = st; Flush = fl;
    endtask

    task automatic idle(logic [31:0] pc);
        setin(pc, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        cycle();
    endtask

    task automatic resolve(logic [31:0] pc, logic [31:0] rpc, bit tk, logic [31:0] tgt);
        setin(pc, 1, rpc, tk, 0, tgt, 0, 0);
        cycle();
    endtask

    logic [31:0] pool_hi [2];

    initial begin
        model_reset();
        reset = 1;
        setin(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        #1;
        cycle(); cycle();
        chk("reset_predict", 32'(s_predict), 32'h0);
        chk("reset_correct", 32'(s_correct), 32'h0);
        reset = 0;

        // First allocation and its visibility one cycle later
        idle(32'h100);
        chk("cold_predict", 32'(s_predict), 32'h0);
        chk("cold_prediction", s_prediction, 32'h0);
        resolve(32'h100, 32'h100, 1, 32'h200);
        chk("no_bypass", 32'(s_predict), 32'h0);
        idle(32'h100);
        chk("alloc_predict", 32'(s_predict), 32'h1);
        chk("alloc_prediction", s_prediction, 32'h200);

        // Counter hysteresis: 10 -> 01 -> 10 -> 11 -> 00 (saturating) -> 01 -> 10
        resolve(32'h300, 32'h100, 0, 32'h0);
        idle(32'h100);
        chk("ctr_01_predict", 32'(s_predict), 32'h0);
        repeat (2) resolve(32'h300, 32'h100, 1, 32'h200);
        idle(32'h100);
        chk("ctr_11_predict", 32'(s_predict), 32'h1);
        repeat (3) resolve(32'h300, 32'h100, 0, 32'h0);
        idle(32'h100);
        chk("ctr_00_predict", 32'(s_predict), 32'h0);
        resolve(32'h300, 32'h100, 0, 32'h0);
        resolve(32'h300, 32'h100, 1, 32'h200);
        idle(32'h100);
        chk("no_underflow", 32'(s_predict), 32'h0);
        resolve(32'h300, 32'h100, 1, 32'h200);

        // Tracking: prediction made at N graded at N+2
        idle(32'h100);
        idle(32'h400);
        resolve(32'h400, 32'h100, 1, 32'h200);
        chk("track_correct", 32'(s_correct), 32'h1);

        // Stall holds the C record; training happens only once
        idle(32'h100);
        idle(32'h500);
        repeat (3) begin
            setin(32'h500, 1, 32'h100, 0, 0, 32'h0, 1, 0);
            cycle();
        end
        chk("stall_hold", 32'(s_correct), 32'h0);
        resolve(32'h500, 32'h100, 0, 32'h0);
        chk("stall_grade", 32'(s_correct), 32'h0);
        idle(32'h100);
        chk("train_once", 32'(s_predict), 32'h1);

        // Wrong target
        idle(32'h100);
        idle(32'h400);
        resolve(32'h400, 32'h100, 1, 32'h204);
        chk("wrong_target", 32'(s_correct), 32'h0);

        // Flush the cycle before resolve kills grading
        idle(32'h100);
        setin(32'h400, 0, 32'h0, 0, 0, 32'h0, 0, 1);
        cycle();
        resolve(32'h400, 32'h100, 1, 32'h204);
        chk("flush_kill", 32'(s_correct), 32'h0);

        // Training under Flush, aliasing into slot of 0x100
        setin(32'h400, 1, 32'h140, 1, 0, 32'h601, 0, 1);
        cycle();
        idle(32'h140);
        chk("flush_train_predict", 32'(s_predict), 32'h1);
        chk("flush_train_target", s_prediction, 32'h600);
        idle(32'h100);
        chk("alias_evict", 32'(s_predict), 32'h0);

        // Jump entries predict taken regardless of the counter
        setin(32'h400, 1, 32'h184, 1, 1, 32'h700, 0, 0);
        cycle();
        repeat (2) resolve(32'h400, 32'h184, 0, 32'h0);
        idle(32'h184);
        chk("jump_sticky", 32'(s_predict), 32'h1);
        chk("jump_target", s_prediction, 32'h700);

        // Randomized traffic over a small aliasing PC pool
        pool_hi[0] = 32'h0000_0000;
        pool_hi[1] = 32'h0000_1000;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, rpc, tgt;
            bit          jmp, tk;
            pc  = pool_hi[$urandom_range(0, 1)] + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            rpc = pool_hi[$urandom_range(0, 1)] + ($urandom_range(0, 15) << 2);
            jmp = ($urandom_range(0, 4) == 0);
            tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       tgt = 32'h200;
                1:       tgt = mc_t | 32'($urandom_range(0, 1));
                2:       tgt = 32'h600;
                default: tgt = $urandom;
            endcase
            reset = ($urandom_range(0, 99) == 0);
            setin(pc, 1'($urandom_range(0, 1)), rpc, tk, jmp, tgt,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            cycle();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
